cht_shift_sequencer: RTL and testbench

- Sequencing controller for the cht-style one-bit shift/hold register stage.
- Accepts queued commands over a valid/ready handshake: CLEAR, LOAD, SHIFT_LEFT, SHIFT_RIGHT by N.
- Drives the stage selects (clear, direction, shift-enable) one step per cycle and owns the WIDTH-bit state register.
- Returns the final register value on a response handshake; sits between the command bus and the shift datapath.

---
 rtl/cht_shift_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_cht_shift_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cht_shift_sequencer.sv
// cht_shift_sequencer
// Sequencing controller for a cht-style one-bit shift/hold register stage.
// It accepts one command at a time (CLEAR, LOAD, SHIFT_LEFT, SHIFT_RIGHT by N)
// and applies at most one shift step per cycle to the WIDTH-bit register it owns.
// When the command is done it returns the register value on a response handshake.
//
// Ports:
//   clk, rst_n           clock (rising edge), synchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; cmd_ready is high only in IDLE
//   cmd_op               00 CLEAR, 01 LOAD, 10 SHIFT_LEFT, 11 SHIFT_RIGHT
//   cmd_amt              shift count N
//   cmd_data             LOAD value
//   cmd_fill             bit inserted at the vacated end on every shift step
//   rsp_valid/rsp_ready  response handshake
//   rsp_data             register value after the command
//   sel_clear            high in the cycle a CLEAR executes
//   sel_dir              1 = left, 0 = right; holds its last value
//   sel_shift            high in each cycle a shift step is applied
//   busy                 high whenever the controller is not IDLE
module cht_shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_fill,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             sel_clear,
    output logic             sel_dir,
    output logic             sel_shift,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0]       OP_CLEAR = 2'b00;
    localparam logic [1:0]       OP_LOAD  = 2'b01;
    localparam logic [1:0]       OP_SHL   = 2'b10;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_r, state_s;
    logic [1:0]         op_r, op_s;
    logic [CNT_W-1:0]   amt_r, amt_s;
    logic [CNT_W-1:0]   count_r, count_s;
    logic [WIDTH-1:0]   data_r, data_s;
    logic               fill_r, fill_s;
    logic [WIDTH-1:0]   shreg_r, shreg_s;
    logic               cmd_ready_r, cmd_ready_s;
    logic               rsp_valid_r, rsp_valid_s;
    logic [WIDTH-1:0]   rsp_data_r, rsp_data_s;
    logic               sel_clear_r, sel_clear_s;
    logic               sel_dir_r, sel_dir_s;
    logic               sel_shift_r, sel_shift_s;
    logic               busy_r, busy_s;
    logic               accept_s;

    // cmd_ready is a flop that resets low, so acceptance keys off it, not off the state.
    assign accept_s = cmd_valid & cmd_ready_r;

    // Next-state, datapath and next-cycle select values.
    always_comb begin
        state_s     = state_r;
        op_s        = op_r;
        amt_s       = amt_r;
        count_s     = count_r;
        data_s      = data_r;
        fill_s      = fill_r;
        shreg_s     = shreg_r;
        sel_clear_s = 1'b0;
        sel_shift_s = 1'b0;
        sel_dir_s   = sel_dir_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    op_s    = cmd_op;
                    amt_s   = cmd_amt;
                    data_s  = cmd_data;
                    fill_s  = cmd_fill;
                    state_s = ST_EXEC;
                    // Selects are registered, so they are raised one edge early
                    // to line up with the cycle that computes the update.
                    if (cmd_op == OP_CLEAR) begin
                        sel_clear_s = 1'b1;
                    end else if (cmd_op[1] && (cmd_amt != CNT_ZERO)) begin
                        sel_dir_s = (cmd_op == OP_SHL);
                    end else begin
                        sel_dir_s = sel_dir_r;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                case (op_r)
                    OP_CLEAR: begin
                        shreg_s = {WIDTH{1'b0}};
                        state_s = ST_RESP;
                    end
                    OP_LOAD: begin
                        shreg_s = data_r;
                        state_s = ST_RESP;
                    end
                    default: begin
                        if (amt_r == CNT_ZERO) begin
                            state_s = ST_RESP;
                        end else begin
                            count_s     = amt_r;
                            sel_shift_s = 1'b1;
                            state_s     = ST_SHIFT;
                        end
                    end
                endcase
            end
            ST_SHIFT: begin
                if (op_r == OP_SHL) begin
                    shreg_s = {shreg_r[WIDTH-2:0], fill_r};
                end else begin
                    shreg_s = {fill_r, shreg_r[WIDTH-1:1]};
                end
                count_s = count_r - CNT_ONE;
                if (count_r == CNT_ONE) begin
                    state_s = ST_RESP;
                end else begin
                    sel_shift_s = 1'b1;
                    state_s     = ST_SHIFT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Registered handshake and status outputs, derived from the next state.
    always_comb begin
        cmd_ready_s = (state_s == ST_IDLE);
        rsp_valid_s = (state_s == ST_RESP);
        busy_s      = (state_s != ST_IDLE);
        if (state_s == ST_RESP) begin
            rsp_data_s = shreg_s;
        end else begin
            rsp_data_s = rsp_data_r;
        end
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            op_r        <= 2'b00;
            amt_r       <= {CNT_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            data_r      <= {WIDTH{1'b0}};
            fill_r      <= 1'b0;
            shreg_r     <= {WIDTH{1'b0}};
            cmd_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {WIDTH{1'b0}};
            sel_clear_r <= 1'b0;
            sel_dir_r   <= 1'b0;
            sel_shift_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            op_r        <= op_s;
            amt_r       <= amt_s;
            count_r     <= count_s;
            data_r      <= data_s;
            fill_r      <= fill_s;
            shreg_r     <= shreg_s;
            cmd_ready_r <= cmd_ready_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_data_r  <= rsp_data_s;
            sel_clear_r <= sel_clear_s;
            sel_dir_r   <= sel_dir_s;
            sel_shift_r <= sel_shift_s;
            busy_r      <= busy_s;
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign sel_clear = sel_clear_r;
    assign sel_dir   = sel_dir_r;
    assign sel_shift = sel_shift_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_cht_shift_sequencer.sv
// Directed bench for cht_shift_sequencer: expected responses are queued when a
// command is issued and compared when the response handshake happens.
module tb_cht_shift_sequencer;

    localparam int W = 16;
    localparam int C = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [C-1:0] cmd_amt = 5'd0;
    logic [W-1:0] cmd_data = 16'h0000;
    logic         cmd_fill = 1'b0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_data;
    logic         sel_clear;
    logic         sel_dir;
    logic         sel_shift;
    logic         busy;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_reg = 16'h0000;
    logic         model_dir = 1'b0;

    int shift_cnt = 0;
    int clear_cnt = 0;
    int busy_cnt  = 0;
    int dir_bad   = 0;
    int ready_bad = 0;

    cht_shift_sequencer #(.WIDTH(W), .CNT_W(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_amt   (cmd_amt),
        .cmd_data  (cmd_data),
        .cmd_fill  (cmd_fill),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .sel_clear (sel_clear),
        .sel_dir   (sel_dir),
        .sel_shift (sel_shift),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Monitor: pulse counters and scoreboard pop on the response handshake.
    always @(negedge clk) begin
        if (sel_shift === 1'b1) begin
            shift_cnt++;
            if (sel_dir !== model_dir) dir_bad++;
        end
        if (sel_clear === 1'b1) clear_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (busy === 1'b1 && cmd_ready === 1'b1) ready_bad++;
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                check("rsp_data", {16'h0000, rsp_data}, {16'h0000, exp_q.pop_front()});
            end
        end
    end

    task automatic stop_now(input string tag);
        $display("FAIL %s: timeout waiting on DUT", tag);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    endtask

    // Issue one command from posedge+1; hold = cycles rsp_ready stays low in RESP.
    task automatic do_cmd(input string tag, input logic [1:0] op, input logic [C-1:0] amt,
                          input logic [W-1:0] data, input logic fill, input int hold);
        int lat;
        int exp_lat;
        int stab_bad;
        bit seen;
        int wait_n;
        wait_n = 0;
        while (cmd_ready !== 1'b1) begin
            @(posedge clk); #1;
            wait_n++;
            if (wait_n > 20) stop_now({tag, "_ready"});
        end
        case (op)
            2'b00: model_reg = 16'h0000;
            2'b01: model_reg = data;
            2'b10: for (int i = 0; i < int'(amt); i++) model_reg = {model_reg[W-2:0], fill};
            default: for (int i = 0; i < int'(amt); i++) model_reg = {fill, model_reg[W-1:1]};
        endcase
        if (op[1] && amt != 5'd0) model_dir = (op == 2'b10);
        exp_lat = (op[1] && amt != 5'd0) ? int'(amt) + 2 : 2;
        exp_q.push_back(model_reg);
        shift_cnt = 0; clear_cnt = 0; busy_cnt = 0; dir_bad = 0; ready_bad = 0;
        cmd_op = op; cmd_amt = amt; cmd_data = data; cmd_fill = fill;
        cmd_valid = 1'b1;
        rsp_ready = (hold == 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = ~op; cmd_data = ~data; cmd_amt = ~amt; cmd_fill = ~fill;
        lat = 1; seen = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin seen = 1; break; end
            @(posedge clk);
            lat++;
        end
        if (!seen) stop_now({tag, "_rsp"});
        check({tag, "_latency"}, lat, exp_lat);
        if (hold > 0) begin
            stab_bad = 0;
            for (int i = 0; i < hold; i++) begin
                if (i > 0) @(negedge clk);
                if (rsp_valid !== 1'b1 || rsp_data !== model_reg) stab_bad++;
                if (i < hold - 1) @(posedge clk);
            end
            check({tag, "_stable"}, stab_bad, 0);
            @(posedge clk); #1;
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, "_idle"}, {29'd0, rsp_valid, busy, cmd_ready}, 32'h1);
        check({tag, "_shifts"}, shift_cnt, (op[1] ? int'(amt) : 0));
        check({tag, "_clears"}, clear_cnt, (op == 2'b00) ? 1 : 0);
        check({tag, "_busy"}, busy_cnt, exp_lat + hold);
        check({tag, "_dir"}, {dir_bad[30:0], sel_dir}, {31'd0, model_dir});
        check({tag, "_ready_busy"}, ready_bad, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int vcnt;
        // Reset held for two edges: everything low.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outs", {24'd0, cmd_ready, rsp_valid, sel_clear, sel_dir, sel_shift, busy, 2'b00}, 32'd0);
        check("reset_data", {16'h0000, rsp_data}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("ready_after_reset", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;

        do_cmd("load_a5c3", 2'b01, 5'd0, 16'hA5C3, 1'b0, 0);
        do_cmd("shl4", 2'b10, 5'd4, 16'h0000, 1'b1, 0);
        check("shl4_const", {16'h0000, model_reg}, 32'h5C3F);

        do_cmd("load_ffff", 2'b01, 5'd0, 16'hFFFF, 1'b1, 0);
        do_cmd("shr20", 2'b11, 5'd20, 16'h0000, 1'b0, 0);
        check("shr20_const", {16'h0000, model_reg}, 32'h0000);

        do_cmd("load_1234", 2'b01, 5'd0, 16'h1234, 1'b0, 0);
        do_cmd("clear_bp", 2'b00, 5'd0, 16'hBEEF, 1'b1, 5);

        do_cmd("load_8001", 2'b01, 5'd0, 16'h8001, 1'b0, 0);
        do_cmd("shl0", 2'b10, 5'd0, 16'h0000, 1'b1, 0);
        do_cmd("shr3", 2'b11, 5'd3, 16'h0000, 1'b1, 0);
        check("shr3_const", {16'h0000, model_reg}, 32'hF000);

        // Reset during the third step of SHIFT_RIGHT N=8.
        cmd_op = 2'b11; cmd_amt = 5'd8; cmd_fill = 1'b1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_step3_shift", {31'd0, sel_shift}, 32'd1);
        @(posedge clk); @(negedge clk);
        check("abort_reset_outs", {26'd0, cmd_ready, rsp_valid, sel_clear, sel_dir, sel_shift, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        vcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) vcnt++;
        end
        check("abort_no_rsp", vcnt, 0);
        model_reg = 16'h0000;
        model_dir = 1'b0;
        @(posedge clk); #1;
        do_cmd("post_abort_shl0", 2'b10, 5'd0, 16'h0000, 1'b0, 0);

        // A few randomized commands.
        do_cmd("rnd_load", 2'b01, 5'd0, 16'($urandom), 1'b0, 0);
        for (int k = 0; k < 4; k++) begin
            do_cmd("rnd_shift", 2'($urandom_range(3, 2)), 5'($urandom_range(17, 0)),
                   16'h0000, 1'($urandom), $urandom_range(2, 0));
        end

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
